mem_lsu: RTL and testbench
==========================

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
REQ-003 ex_wd  in  5  destination register address from EX/MEM.
REQ-004 ex_wreg  in  1  register-write enable from EX/MEM.
REQ-005 ex_wdata  in  32  ALU result; written back for non-memory ops.
REQ-006 mem_op  in  4  0=NONE 1=LB 2=LBU 3=LH 4=LHU 5=LW 6=SB 7=SH 8=SW; 9-15 decode as NONE.
REQ-007 mem_addr  in  32  effective byte address.
REQ-008 store_data  in  32  rt value for stores.
REQ-009 mem_wd / mem_wreg / mem_wdata  out  5/1/32  result to MEM/WB register.
REQ-010 dbus_req  out  1  data-bus request; dbus_we out 1; dbus_addr out 32 (addr[1:0] forced 00); dbus_sel out 4 byte enables; dbus_wdata out 32.
REQ-011 dbus_ack  in  1  slave completion, one-cycle pulse; dbus_rdata in 32 valid when dbus_ack=1.
REQ-012 stallreq  out  1  freeze PC..EX/MEM; upstream holds all inputs stable while 1.
REQ-013 addr_err  out  1  misaligned access flag, combinational.

Function
REQ-014 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-015 NONE in IDLE: mem_wd=ex_wd, mem_wreg=ex_wreg, mem_wdata=ex_wdata same cycle, stallreq=0, dbus_req=0.
REQ-016 aligned memory op in IDLE: dbus_req=1, stallreq=1; dbus_ack=1 same cycle -> DONE, else -> BUSY.
REQ-017 BUSY: dbus_req=1, stallreq=1, bus outputs constant; dbus_ack=1 -> DONE; no timeout.
REQ-018 on ack edge, dbus_rdata captured into internal 32-bit register; ack ignored while dbus_req=0.
REQ-019 DONE: dbus_req=0, stallreq=0, result presented; unconditional -> IDLE next edge.
REQ-020 minimum memory-op latency 2 cycles (IDLE+DONE); each BUSY cycle adds 1.
REQ-021 big-endian lanes: byte offset 00->sel 1000 (bits 31:24), 01->0100, 10->0010, 11->0001; half offset 00->1100, 10->0011; word->1111.
REQ-022 loads: dbus_we=0; LB/LH sign-extend, LBU/LHU zero-extend selected lane; LW whole word; mem_wd=ex_wd, mem_wreg=ex_wreg in DONE.
REQ-023 stores: dbus_we=1; SB dbus_wdata={4{store_data[7:0]}}, SH {2{store_data[15:0]}}, SW store_data; mem_wreg=0 in DONE.
REQ-024 misaligned (LH/LHU/SH addr[0]=1; LW/SW addr[1:0]!=0): addr_err=1, dbus_req=0, stallreq=0, mem_wreg=0, mem_wd=0, mem_wdata=0, FSM stays IDLE.
REQ-025 addr_err=0 in BUSY and DONE and for NONE.
REQ-026 in BUSY/DONE outputs come from latched op/addr/lane info, not live inputs.
REQ-027 dbus_wdata=0 and dbus_sel=0 whenever dbus_req=0.

Reset
REQ-028 rst=0: FSM->IDLE, capture register=0; dbus_req=0, stallreq=0, mem_wreg=0, mem_wd=0, mem_wdata=0, addr_err=0.
REQ-029 reset during BUSY abandons the transaction; a later dbus_ack while IDLE with no request is ignored.
REQ-030 after rst rises, first edge evaluates inputs as a fresh IDLE cycle.

Verification
REQ-031 NONE, ex_wd=5, ex_wreg=1, ex_wdata=0x1234 -> same cycle mem_wdata=0x1234, mem_wreg=1, stallreq=0, dbus_req=0.
REQ-032 LB addr=0x101, ack after 2 BUSY cycles, rdata=0x11F23344 -> sel=0100, stallreq=1 for 3 cycles, DONE mem_wdata=0xFFFFFFF2, mem_wreg=1.
REQ-033 LHU addr=0x102, ack in IDLE, rdata=0xAAAA8001 -> DONE next cycle, mem_wdata=0x00008001; total 2 cycles.
REQ-034 SH addr=0x200, store_data=0xDEADBEEF -> dbus_we=1, sel=1100, dbus_wdata=0xBEEFBEEF, mem_wreg=0 in DONE.
REQ-035 LW addr=0x203 -> addr_err=1, dbus_req=0, stallreq=0, mem_wreg=0, FSM stays IDLE.
REQ-036 SW issued, rst=0 in BUSY, late dbus_ack after release -> all outputs 0, FSM IDLE, no write-back.

Source files
------------

// File: rtl/mem_lsu_if.sv
// rtl/mem_lsu_if.sv - data-bus handshake between the load/store unit and the memory slave
interface mem_lsu_if;
   logic        dbus_req;
   logic        dbus_we;
   logic [31:0] dbus_addr;
   logic [3:0]  dbus_sel;
   logic [31:0] dbus_wdata;
   logic        dbus_ack;
   logic [31:0] dbus_rdata;

   modport master (
      output dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata,
      input  dbus_ack, dbus_rdata
   );

   modport slave (
      input  dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata,
      output dbus_ack, dbus_rdata
   );
endinterface

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - MEM-stage load/store unit with big-endian byte lanes and a stalling bus FSM
module mem_lsu (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  ex_wd,
   input  logic        ex_wreg,
   input  logic [31:0] ex_wdata,
   input  logic [3:0]  mem_op,
   input  logic [31:0] mem_addr,
   input  logic [31:0] store_data,
   output logic [4:0]  mem_wd,
   output logic        mem_wreg,
   output logic [31:0] mem_wdata,
   mem_lsu_if.master   bus,
   output logic        stallreq,
   output logic        addr_err
);

   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LBU = 4'd2;
   localparam logic [3:0] OP_LH  = 4'd3;
   localparam logic [3:0] OP_LHU = 4'd4;
   localparam logic [3:0] OP_LW  = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state_q, state_d;
   logic [3:0]  op_q;
   logic [31:0] addr_q;
   logic [31:0] sd_q;
   logic [4:0]  wd_q;
   logic        wreg_q;
   logic [31:0] cap_q;

   logic [3:0]  op_c;
   logic [31:0] addr_c;
   logic [31:0] sd_c;
   logic [1:0]  off;
   logic        is_load, is_store, is_mem, sgn, misalign, go;
   logic [1:0]  size;
   logic [3:0]  lane_sel;
   logic [31:0] lane_wdata;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] load_val;

   logic        req;
   logic        we;
   logic [31:0] baddr;
   logic [3:0]  bsel;
   logic [31:0] bwdata;

   // Once a transaction is launched everything is driven from the latched copy.
   always_comb begin
      if (state_q == IDLE) begin
         op_c   = mem_op;
         addr_c = mem_addr;
         sd_c   = store_data;
      end else begin
         op_c   = op_q;
         addr_c = addr_q;
         sd_c   = sd_q;
      end
   end

   assign off = addr_c[1:0];

   always_comb begin
      is_load  = 1'b0;
      is_store = 1'b0;
      size     = SZ_B;
      sgn      = 1'b0;
      case (op_c)
         OP_LB:   begin is_load  = 1'b1; size = SZ_B; sgn = 1'b1; end
         OP_LBU:  begin is_load  = 1'b1; size = SZ_B;             end
         OP_LH:   begin is_load  = 1'b1; size = SZ_H; sgn = 1'b1; end
         OP_LHU:  begin is_load  = 1'b1; size = SZ_H;             end
         OP_LW:   begin is_load  = 1'b1; size = SZ_W;             end
         OP_SB:   begin is_store = 1'b1; size = SZ_B;             end
         OP_SH:   begin is_store = 1'b1; size = SZ_H;             end
         OP_SW:   begin is_store = 1'b1; size = SZ_W;             end
         default: ;
      endcase
   end

   assign is_mem   = is_load | is_store;
   assign misalign = is_mem && (((size == SZ_H) && off[0]) ||
                                ((size == SZ_W) && (off != 2'b00)));
   assign go       = (state_q == IDLE) && is_mem && !misalign;

   // Byte lane 0 of the word is bits 31:24 (big-endian).
   always_comb begin
      lane_sel   = 4'b1111;
      lane_wdata = sd_c;
      case (size)
         SZ_B: begin
            lane_sel   = 4'b1000 >> off;
            lane_wdata = {4{sd_c[7:0]}};
         end
         SZ_H: begin
            lane_sel   = off[1] ? 4'b0011 : 4'b1100;
            lane_wdata = {2{sd_c[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      ld_byte = cap_q[31:24];
      case (addr_q[1:0])
         2'b00:   ld_byte = cap_q[31:24];
         2'b01:   ld_byte = cap_q[23:16];
         2'b10:   ld_byte = cap_q[15:8];
         default: ld_byte = cap_q[7:0];
      endcase
      ld_half = addr_q[1] ? cap_q[15:0] : cap_q[31:16];
      case (size)
         SZ_B:    load_val = {{24{sgn & ld_byte[7]}}, ld_byte};
         SZ_H:    load_val = {{16{sgn & ld_half[15]}}, ld_half};
         default: load_val = cap_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (go) state_d = bus.dbus_ack ? DONE : BUSY;
         BUSY:    if (bus.dbus_ack) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req       = 1'b0;
      we        = 1'b0;
      baddr     = 32'd0;
      bsel      = 4'd0;
      bwdata    = 32'd0;
      stallreq  = 1'b0;
      addr_err  = 1'b0;
      mem_wd    = 5'd0;
      mem_wreg  = 1'b0;
      mem_wdata = 32'd0;
      if (rst) begin
         case (state_q)
            IDLE: begin
               if (!is_mem) begin
                  mem_wd    = ex_wd;
                  mem_wreg  = ex_wreg;
                  mem_wdata = ex_wdata;
               end else if (misalign) begin
                  addr_err = 1'b1;
               end else begin
                  req      = 1'b1;
                  stallreq = 1'b1;
                  we       = is_store;
                  baddr    = {addr_c[31:2], 2'b00};
                  bsel     = lane_sel;
                  bwdata   = is_store ? lane_wdata : 32'd0;
               end
            end
            BUSY: begin
               req      = 1'b1;
               stallreq = 1'b1;
               we       = is_store;
               baddr    = {addr_c[31:2], 2'b00};
               bsel     = lane_sel;
               bwdata   = is_store ? lane_wdata : 32'd0;
            end
            DONE: begin
               if (is_load) begin
                  mem_wd    = wd_q;
                  mem_wreg  = wreg_q;
                  mem_wdata = load_val;
               end
            end
            default: ;
         endcase
      end
   end

   // Launch latch and read-data capture; ack only counts while a request is out.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q   <= 4'd0;
         addr_q <= 32'd0;
         sd_q   <= 32'd0;
         wd_q   <= 5'd0;
         wreg_q <= 1'b0;
         cap_q  <= 32'd0;
      end else begin
         if (go) begin
            op_q   <= mem_op;
            addr_q <= mem_addr;
            sd_q   <= store_data;
            wd_q   <= ex_wd;
            wreg_q <= ex_wreg;
         end
         if (req && bus.dbus_ack) begin
            cap_q <= bus.dbus_rdata;
         end
      end
   end

   assign bus.dbus_req   = req;
   assign bus.dbus_we    = we;
   assign bus.dbus_addr  = baddr;
   assign bus.dbus_sel   = bsel;
   assign bus.dbus_wdata = bwdata;

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - directed self-checking bench for mem_lsu
module tb_mem_lsu;
   localparam logic [3:0] NONE = 4'd0;
   localparam logic [3:0] LB   = 4'd1;
   localparam logic [3:0] LBU  = 4'd2;
   localparam logic [3:0] LH   = 4'd3;
   localparam logic [3:0] LHU  = 4'd4;
   localparam logic [3:0] LW   = 4'd5;
   localparam logic [3:0] SB   = 4'd6;
   localparam logic [3:0] SH   = 4'd7;
   localparam logic [3:0] SW   = 4'd8;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  ex_wd;
   logic        ex_wreg;
   logic [31:0] ex_wdata;
   logic [3:0]  mem_op;
   logic [31:0] mem_addr;
   logic [31:0] store_data;
   logic [4:0]  mem_wd;
   logic        mem_wreg;
   logic [31:0] mem_wdata;
   logic        stallreq;
   logic        addr_err;

   int n_tests = 0;
   int n_fail  = 0;

   mem_lsu_if bus ();

   mem_lsu dut (
      .clk        (clk),
      .rst        (rst),
      .ex_wd      (ex_wd),
      .ex_wreg    (ex_wreg),
      .ex_wdata   (ex_wdata),
      .mem_op     (mem_op),
      .mem_addr   (mem_addr),
      .store_data (store_data),
      .mem_wd     (mem_wd),
      .mem_wreg   (mem_wreg),
      .mem_wdata  (mem_wdata),
      .bus        (bus),
      .stallreq   (stallreq),
      .addr_err   (addr_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                         input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
      mem_op     = op;
      mem_addr   = addr;
      store_data = sd;
      ex_wd      = wd;
      ex_wreg    = wreg;
      ex_wdata   = wdata;
   endtask

   // Single-cycle ack in the launch cycle, then check the DONE result.
   task automatic quick_load(input string tag, input logic [3:0] op, input logic [31:0] addr,
                             input logic [31:0] rdata, input logic [3:0] sel_exp,
                             input logic [31:0] res_exp);
      tick();
      set_in(op, addr, 32'd0, 5'd10, 1'b1, 32'd0);
      bus.dbus_ack   = 1'b1;
      bus.dbus_rdata = rdata;
      #2;
      check({tag, "_sel"}, {28'd0, bus.dbus_sel}, {28'd0, sel_exp});
      check({tag, "_we"}, {31'd0, bus.dbus_we}, 32'd0);
      tick();
      bus.dbus_ack = 1'b0;
      #2;
      check({tag, "_done_stall"}, {31'd0, stallreq}, 32'd0);
      check({tag, "_data"}, mem_wdata, res_exp);
      check({tag, "_wreg"}, {31'd0, mem_wreg}, 32'd1);
   endtask

   initial begin
      rst            = 1'b0;
      bus.dbus_ack   = 1'b0;
      bus.dbus_rdata = 32'd0;
      set_in(NONE, 32'd0, 32'd0, 5'd5, 1'b1, 32'h1234);
      #2;
      check("rst_wreg", {31'd0, mem_wreg}, 32'd0);
      check("rst_wd", {27'd0, mem_wd}, 32'd0);
      check("rst_wdata", mem_wdata, 32'd0);
      check("rst_req", {31'd0, bus.dbus_req}, 32'd0);
      check("rst_stall", {31'd0, stallreq}, 32'd0);
      set_in(LW, 32'h203, 32'd0, 5'd5, 1'b1, 32'h1234);
      #1;
      check("rst_addr_err", {31'd0, addr_err}, 32'd0);
      tick();
      tick();
      rst = 1'b1;

      set_in(NONE, 32'd0, 32'd0, 5'd5, 1'b1, 32'h1234);
      #2;
      check("none_wdata", mem_wdata, 32'h1234);
      check("none_wreg", {31'd0, mem_wreg}, 32'd1);
      check("none_wd", {27'd0, mem_wd}, 32'd5);
      check("none_stall", {31'd0, stallreq}, 32'd0);
      check("none_req", {31'd0, bus.dbus_req}, 32'd0);

      // LB 0x101 with two BUSY cycles
      tick();
      set_in(LB, 32'h101, 32'd0, 5'd7, 1'b1, 32'd0);
      #2;
      check("lb_idle_req", {31'd0, bus.dbus_req}, 32'd1);
      check("lb_idle_stall", {31'd0, stallreq}, 32'd1);
      check("lb_sel", {28'd0, bus.dbus_sel}, 32'h4);
      check("lb_we", {31'd0, bus.dbus_we}, 32'd0);
      check("lb_addr", bus.dbus_addr, 32'h100);
      tick();
      #2;
      check("lb_busy1_stall", {31'd0, stallreq}, 32'd1);
      check("lb_busy1_sel", {28'd0, bus.dbus_sel}, 32'h4);
      tick();
      bus.dbus_ack   = 1'b1;
      bus.dbus_rdata = 32'h11F23344;
      #2;
      check("lb_busy2_stall", {31'd0, stallreq}, 32'd1);
      tick();
      bus.dbus_ack   = 1'b0;
      bus.dbus_rdata = 32'd0;
      #2;
      check("lb_done_stall", {31'd0, stallreq}, 32'd0);
      check("lb_done_req", {31'd0, bus.dbus_req}, 32'd0);
      check("lb_done_sel", {28'd0, bus.dbus_sel}, 32'd0);
      check("lb_done_data", mem_wdata, 32'hFFFFFFF2);
      check("lb_done_wreg", {31'd0, mem_wreg}, 32'd1);
      check("lb_done_wd", {27'd0, mem_wd}, 32'd7);

      // LHU 0x102 acked in the launch cycle
      tick();
      set_in(LHU, 32'h102, 32'd0, 5'd3, 1'b1, 32'd0);
      bus.dbus_ack   = 1'b1;
      bus.dbus_rdata = 32'hAAAA8001;
      #2;
      check("lhu_sel", {28'd0, bus.dbus_sel}, 32'h3);
      check("lhu_req", {31'd0, bus.dbus_req}, 32'd1);
      tick();
      bus.dbus_ack = 1'b0;
      #2;
      check("lhu_done_stall", {31'd0, stallreq}, 32'd0);
      check("lhu_done_data", mem_wdata, 32'h00008001);
      check("lhu_done_wreg", {31'd0, mem_wreg}, 32'd1);

      // SH 0x200 with one BUSY cycle
      tick();
      set_in(SH, 32'h200, 32'hDEADBEEF, 5'd9, 1'b1, 32'd0);
      #2;
      check("sh_we", {31'd0, bus.dbus_we}, 32'd1);
      check("sh_sel", {28'd0, bus.dbus_sel}, 32'hC);
      check("sh_wdata", bus.dbus_wdata, 32'hBEEFBEEF);
      check("sh_addr", bus.dbus_addr, 32'h200);
      tick();
      bus.dbus_ack = 1'b1;
      #2;
      check("sh_busy_wdata", bus.dbus_wdata, 32'hBEEFBEEF);
      check("sh_busy_stall", {31'd0, stallreq}, 32'd1);
      tick();
      bus.dbus_ack = 1'b0;
      #2;
      check("sh_done_wreg", {31'd0, mem_wreg}, 32'd0);
      check("sh_done_stall", {31'd0, stallreq}, 32'd0);
      check("sh_done_wdata", bus.dbus_wdata, 32'd0);
      check("sh_done_sel", {28'd0, bus.dbus_sel}, 32'd0);

      // LW misaligned
      tick();
      set_in(LW, 32'h203, 32'd0, 5'd4, 1'b1, 32'h55);
      #2;
      check("lw_mis_err", {31'd0, addr_err}, 32'd1);
      check("lw_mis_req", {31'd0, bus.dbus_req}, 32'd0);
      check("lw_mis_stall", {31'd0, stallreq}, 32'd0);
      check("lw_mis_wreg", {31'd0, mem_wreg}, 32'd0);
      check("lw_mis_wd", {27'd0, mem_wd}, 32'd0);
      check("lw_mis_wdata", mem_wdata, 32'd0);
      tick();
      set_in(NONE, 32'd0, 32'd0, 5'd4, 1'b1, 32'h55);
      #2;
      check("lw_mis_idle", mem_wdata, 32'h55);
      check("none_err", {31'd0, addr_err}, 32'd0);

      // SB at offset 3, acked immediately
      tick();
      set_in(SB, 32'h003, 32'h123456A5, 5'd2, 1'b1, 32'd0);
      bus.dbus_ack = 1'b1;
      #2;
      check("sb_sel", {28'd0, bus.dbus_sel}, 32'h1);
      check("sb_wdata", bus.dbus_wdata, 32'hA5A5A5A5);
      check("sb_we", {31'd0, bus.dbus_we}, 32'd1);
      tick();
      bus.dbus_ack = 1'b0;
      #2;
      check("sb_done_wreg", {31'd0, mem_wreg}, 32'd0);
      check("sb_done_stall", {31'd0, stallreq}, 32'd0);

      quick_load("lh0", LH, 32'h100, 32'h80011234, 4'hC, 32'hFFFF8001);
      quick_load("lbu3", LBU, 32'h103, 32'h000000F0, 4'h1, 32'h000000F0);
      quick_load("lb0", LB, 32'h100, 32'h7F000000, 4'h8, 32'h0000007F);
      quick_load("lw0", LW, 32'h104, 32'h01020304, 4'hF, 32'h01020304);

      // SW aborted by reset in BUSY, late ack afterwards
      tick();
      set_in(SW, 32'h300, 32'hCAFEF00D, 5'd8, 1'b1, 32'd0);
      #2;
      check("sw_req", {31'd0, bus.dbus_req}, 32'd1);
      check("sw_wdata", bus.dbus_wdata, 32'hCAFEF00D);
      tick();
      #2;
      check("sw_busy_stall", {31'd0, stallreq}, 32'd1);
      #1;
      rst = 1'b0;
      #1;
      check("abort_req", {31'd0, bus.dbus_req}, 32'd0);
      check("abort_stall", {31'd0, stallreq}, 32'd0);
      check("abort_wdata_bus", bus.dbus_wdata, 32'd0);
      tick();
      rst = 1'b1;
      set_in(NONE, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
      bus.dbus_ack   = 1'b1;
      bus.dbus_rdata = 32'hFFFFFFFF;
      #2;
      check("late_ack_req", {31'd0, bus.dbus_req}, 32'd0);
      check("late_ack_stall", {31'd0, stallreq}, 32'd0);
      check("late_ack_wreg", {31'd0, mem_wreg}, 32'd0);
      check("late_ack_wdata", mem_wdata, 32'd0);
      tick();
      bus.dbus_ack = 1'b0;
      set_in(NONE, 32'd0, 32'd0, 5'd6, 1'b1, 32'hABC);
      #2;
      check("post_abort_idle", mem_wdata, 32'hABC);
      check("post_abort_stall", {31'd0, stallreq}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
